// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS write-back stage: WB pipeline register, load extraction, result mux, HI/LO.
// Optional LWL/LWR merge for LoadSize 11 is enabled by defining WB_UNALIGNED_LOAD_EN.
module wb_stage #(
   parameter logic [31:0] PC_RESET    = 32'hBFC0_0000,
   parameter logic [31:0] LINK_OFFSET = 32'd8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WB_Flush,
   input  logic        WB_Wr,
   input  logic [31:0] MEM_ALUOut,
   input  logic [31:0] MEM_OutB,
   input  logic [31:0] MEM_DMOut,
   input  logic [31:0] MEM_PC,
   input  logic [31:0] MEM_Instr,
   input  logic [1:0]  MEM_LoadSize,
   input  logic        MEM_LoadSign,
   input  logic [1:0]  MEM_WbSel,
   input  logic [4:0]  MEM_Dst,
   input  logic [2:0]  MEM_RegsWrType_final,
   input  logic [31:0] MEM_Hi,
   input  logic [31:0] MEM_Lo,
   output logic        WB_RFWr,
   output logic [4:0]  WB_Dst,
   output logic [31:0] WB_Result,
   output logic [31:0] WB_HI,
   output logic [31:0] WB_LO,
   output logic [31:0] WB_PC,
   output logic [3:0]  debug_wb_rf_wen
);

   typedef struct packed {
      logic [2:0]  rwt;
      logic [4:0]  dst;
      logic [1:0]  wbsel;
      logic [1:0]  lsize;
      logic        lsign;
      logic [31:0] alu;
      logic [31:0] outb;
      logic [31:0] dm;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] hi;
      logic [31:0] lo;
   } wb_reg_t;

   localparam wb_reg_t BUBBLE = '{pc: PC_RESET, default: '0};

   wb_reg_t     wb_q, wb_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] load_data;
   logic [15:0] half_v;
   logic [7:0]  byte_v;
   logic [1:0]  off;
   logic        rf_wr;

   // Flush beats stall: a flushed slot becomes a bubble even when WB_Wr is low.
   always_comb begin
      wb_d = wb_q;
      if (WB_Flush) begin
         wb_d = BUBBLE;
      end else if (WB_Wr) begin
         wb_d.rwt   = MEM_RegsWrType_final;
         wb_d.dst   = MEM_Dst;
         wb_d.wbsel = MEM_WbSel;
         wb_d.lsize = MEM_LoadSize;
         wb_d.lsign = MEM_LoadSign;
         wb_d.alu   = MEM_ALUOut;
         wb_d.outb  = MEM_OutB;
         wb_d.dm    = MEM_DMOut;
         wb_d.pc    = MEM_PC;
         wb_d.instr = MEM_Instr;
         wb_d.hi    = MEM_Hi;
         wb_d.lo    = MEM_Lo;
      end
   end

   // HI/LO commit only on the instruction's final WB cycle, so stalls never double-write.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (wb_q.rwt[1] && WB_Wr) hi_d = wb_q.hi;
      if (wb_q.rwt[0] && WB_Wr) lo_d = wb_q.lo;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_q <= BUBBLE;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         wb_q <= wb_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   always_comb begin
      off       = wb_q.alu[1:0];
      half_v    = off[1] ? wb_q.dm[31:16] : wb_q.dm[15:0];
      byte_v    = wb_q.dm[{off, 3'b000} +: 8];
      load_data = wb_q.dm;
      case (wb_q.lsize)
         2'b01:   load_data = {{16{wb_q.lsign & half_v[15]}}, half_v};
         2'b10:   load_data = {{24{wb_q.lsign & byte_v[7]}}, byte_v};
`ifdef WB_UNALIGNED_LOAD_EN
         2'b11: begin
            if (!wb_q.lsign) begin
               case (off)
                  2'd0:    load_data = {wb_q.dm[7:0],  wb_q.outb[23:0]};
                  2'd1:    load_data = {wb_q.dm[15:0], wb_q.outb[15:0]};
                  2'd2:    load_data = {wb_q.dm[23:0], wb_q.outb[7:0]};
                  default: load_data = wb_q.dm;
               endcase
            end else begin
               case (off)
                  2'd1:    load_data = {wb_q.outb[31:24], wb_q.dm[31:8]};
                  2'd2:    load_data = {wb_q.outb[31:16], wb_q.dm[31:16]};
                  2'd3:    load_data = {wb_q.outb[31:8],  wb_q.dm[31:24]};
                  default: load_data = wb_q.dm;
               endcase
            end
         end
`else
         2'b11:   load_data = wb_q.dm;
`endif
         default: load_data = wb_q.dm;
      endcase
   end

   always_comb begin
      case (wb_q.wbsel)
         2'b00:   WB_Result = wb_q.alu;
         2'b01:   WB_Result = wb_q.outb;
         2'b10:   WB_Result = load_data;
         default: WB_Result = wb_q.pc + LINK_OFFSET;
      endcase
   end

   assign rf_wr           = wb_q.rwt[2] & (wb_q.dst != 5'd0);
   assign WB_RFWr         = rf_wr;
   assign WB_Dst          = wb_q.dst;
   assign WB_PC           = wb_q.pc;
   assign WB_HI           = hi_q;
   assign WB_LO           = lo_q;
   assign debug_wb_rf_wen = {4{rf_wr & WB_Wr}};

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage (directed steps plus random byte/half loads).
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        WB_Flush, WB_Wr;
   logic [31:0] MEM_ALUOut, MEM_OutB, MEM_DMOut, MEM_PC, MEM_Instr, MEM_Hi, MEM_Lo;
   logic [1:0]  MEM_LoadSize, MEM_WbSel;
   logic        MEM_LoadSign;
   logic [4:0]  MEM_Dst;
   logic [2:0]  MEM_RegsWrType_final;
   logic        WB_RFWr;
   logic [4:0]  WB_Dst;
   logic [31:0] WB_Result, WB_HI, WB_LO, WB_PC;
   logic [3:0]  debug_wb_rf_wen;

   int n_chk  = 0;
   int n_fail = 0;
   int traces = 0;

   typedef struct {
      string       tag;
      logic        rfwr;
      logic [4:0]  dst;
      logic [31:0] result;
      logic [31:0] pc;
   } exp_t;
   exp_t sb[$];

   wb_stage dut (
      .clk(clk), .rst(rst), .WB_Flush(WB_Flush), .WB_Wr(WB_Wr),
      .MEM_ALUOut(MEM_ALUOut), .MEM_OutB(MEM_OutB), .MEM_DMOut(MEM_DMOut),
      .MEM_PC(MEM_PC), .MEM_Instr(MEM_Instr), .MEM_LoadSize(MEM_LoadSize),
      .MEM_LoadSign(MEM_LoadSign), .MEM_WbSel(MEM_WbSel), .MEM_Dst(MEM_Dst),
      .MEM_RegsWrType_final(MEM_RegsWrType_final), .MEM_Hi(MEM_Hi), .MEM_Lo(MEM_Lo),
      .WB_RFWr(WB_RFWr), .WB_Dst(WB_Dst), .WB_Result(WB_Result), .WB_HI(WB_HI),
      .WB_LO(WB_LO), .WB_PC(WB_PC), .debug_wb_rf_wen(debug_wb_rf_wen)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input logic [1:0] size, input logic sign, input logic [1:0] wbsel,
                          input logic [4:0] dst, input logic [2:0] rwt, input logic [31:0] alu,
                          input logic [31:0] outb, input logic [31:0] dm, input logic [31:0] pc,
                          input logic [31:0] hi, input logic [31:0] lo);
      MEM_LoadSize = size; MEM_LoadSign = sign; MEM_WbSel = wbsel; MEM_Dst = dst;
      MEM_RegsWrType_final = rwt; MEM_ALUOut = alu; MEM_OutB = outb; MEM_DMOut = dm;
      MEM_PC = pc; MEM_Hi = hi; MEM_Lo = lo; MEM_Instr = pc ^ 32'h5A5A_0000;
   endtask

   task automatic push(input string tag, input logic rfwr, input logic [4:0] dst,
                       input logic [31:0] result, input logic [31:0] pc);
      exp_t e;
      e.tag = tag; e.rfwr = rfwr; e.dst = dst; e.result = result; e.pc = pc;
      sb.push_back(e);
   endtask

   // Captures the driven MEM values and scores the WB outputs one cycle later.
   task automatic issue_and_check();
      exp_t e;
      tick();
      if (sb.size() == 0) begin
         n_chk++; n_fail++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         check({e.tag, "_rfwr"},   {31'd0, WB_RFWr}, {31'd0, e.rfwr});
         check({e.tag, "_dst"},    {27'd0, WB_Dst},  {27'd0, e.dst});
         check({e.tag, "_result"}, WB_Result,        e.result);
         check({e.tag, "_pc"},     WB_PC,            e.pc);
         check({e.tag, "_wen"},    {28'd0, debug_wb_rf_wen}, {28'd0, {4{e.rfwr & WB_Wr}}});
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sign,
                                            input logic [1:0] o, input logic [31:0] d);
      logic [31:0] v;
      if (size == 2'b10) begin
         v = (d >> (o * 8)) & 32'h0000_00FF;
         if (sign && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
         v = o[1] ? (d >> 16) : (d & 32'h0000_FFFF);
         if (sign && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = d;
      end
      return v;
   endfunction

   initial begin
      logic [31:0] d, a, exp_r;
      logic [1:0]  sz;
      logic        sg;
      logic [4:0]  dst;

      rst = 1'b1; WB_Flush = 1'b0; WB_Wr = 1'b0;
      set_mem(2'b00, 1'b0, 2'b00, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      tick(); tick();
      check("rst_rfwr",  {31'd0, WB_RFWr}, 32'd0);
      check("rst_pc",    WB_PC, 32'hBFC0_0000);
      check("rst_result", WB_Result, 32'd0);
      check("rst_hi",    WB_HI, 32'd0);
      check("rst_lo",    WB_LO, 32'd0);
      check("rst_wen",   {28'd0, debug_wb_rf_wen}, 32'd0);
      rst = 1'b0;
      tick();
      check("idle_pc",   WB_PC, 32'hBFC0_0000);
      check("idle_rfwr", {31'd0, WB_RFWr}, 32'd0);

      WB_Wr = 1'b1;
      set_mem(2'b10, 1'b1, 2'b10, 5'd5, 3'b100, 32'h0000_1001, 32'd0, 32'h8055_AA7F,
              32'hBFC0_0100, 32'd0, 32'd0);
      push("lb", 1'b1, 5'd5, 32'hFFFF_FFAA, 32'hBFC0_0100);
      issue_and_check();
      set_mem(2'b01, 1'b0, 2'b10, 5'd5, 3'b100, 32'h0000_1002, 32'd0, 32'h8055_AA7F,
              32'hBFC0_0104, 32'd0, 32'd0);
      push("lhu", 1'b1, 5'd5, 32'h0000_8055, 32'hBFC0_0104);
      issue_and_check();

      for (int i = 0; i < 12; i++) begin
         d   = $urandom;
         a   = $urandom;
         sz  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         sg  = 1'($urandom_range(0, 1));
         dst = 5'($urandom_range(0, 31));
         exp_r = ref_load(sz, sg, a[1:0], d);
         set_mem(sz, sg, 2'b10, dst, 3'b100, a, 32'd0, d, 32'h1000_0000 + i * 4, 32'd0, 32'd0);
         push("rnd_load", dst != 5'd0, dst, exp_r, 32'h1000_0000 + i * 4);
         issue_and_check();
      end

      set_mem(2'b00, 1'b0, 2'b11, 5'd31, 3'b100, 32'd0, 32'd0, 32'd0, 32'hBFC0_0010, 32'd0, 32'd0);
      push("jal", 1'b1, 5'd31, 32'hBFC0_0018, 32'hBFC0_0010);
      issue_and_check();
      set_mem(2'b00, 1'b0, 2'b11, 5'd0, 3'b100, 32'd0, 32'd0, 32'd0, 32'hBFC0_0010, 32'd0, 32'd0);
      push("jal_r0", 1'b0, 5'd0, 32'hBFC0_0018, 32'hBFC0_0010);
      issue_and_check();
      set_mem(2'b00, 1'b0, 2'b11, 5'd31, 3'b100, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, 32'd0);
      push("link_wrap", 1'b1, 5'd31, 32'h0000_0004, 32'hFFFF_FFFC);
      issue_and_check();
      set_mem(2'b00, 1'b0, 2'b01, 5'd7, 3'b100, 32'h1111_1111, 32'hCAFE_F00D, 32'd0,
              32'hBFC0_0200, 32'd0, 32'd0);
      push("outb", 1'b1, 5'd7, 32'hCAFE_F00D, 32'hBFC0_0200);
      issue_and_check();

`ifdef WB_UNALIGNED_LOAD_EN
      exp_r = 32'h2211_CCDD;
`else
      exp_r = 32'h4433_2211;
`endif
      set_mem(2'b11, 1'b0, 2'b10, 5'd3, 3'b100, 32'h0000_2001, 32'hAABB_CCDD, 32'h4433_2211,
              32'hBFC0_0300, 32'd0, 32'd0);
      push("lwl", 1'b1, 5'd3, exp_r, 32'hBFC0_0300);
      issue_and_check();
`ifdef WB_UNALIGNED_LOAD_EN
      exp_r = 32'hAA44_3322;
`else
      exp_r = 32'h4433_2211;
`endif
      set_mem(2'b11, 1'b1, 2'b10, 5'd3, 3'b100, 32'h0000_2001, 32'hAABB_CCDD, 32'h4433_2211,
              32'hBFC0_0304, 32'd0, 32'd0);
      push("lwr", 1'b1, 5'd3, exp_r, 32'hBFC0_0304);
      issue_and_check();

      // MULT-like result held in WB by a 3-cycle stall: one trace, one HI/LO write.
      set_mem(2'b00, 1'b0, 2'b00, 5'd9, 3'b111, 32'h0000_0042, 32'd0, 32'd0,
              32'hBFC0_0400, 32'h0000_0001, 32'hFFFF_FFFE);
      push("mult", 1'b1, 5'd9, 32'h0000_0042, 32'hBFC0_0400);
      tick();
      WB_Wr = 1'b0;
      #1;
      set_mem(2'b00, 1'b0, 2'b00, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0, 32'hBFC0_0404, 32'd0, 32'd0);
      traces = 0;
      for (int i = 0; i < 3; i++) begin
         if (debug_wb_rf_wen == 4'hF) traces++;
         check("stall_hi", WB_HI, 32'd0);
         check("stall_lo", WB_LO, 32'd0);
         tick();
      end
      WB_Wr = 1'b1;
      #1;
      if (debug_wb_rf_wen == 4'hF) traces++;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, "_dst"},    {27'd0, WB_Dst}, {27'd0, e.dst});
         check({e.tag, "_result"}, WB_Result, e.result);
      end
      tick();
      if (debug_wb_rf_wen == 4'hF) traces++;
      check("mult_hi", WB_HI, 32'h0000_0001);
      check("mult_lo", WB_LO, 32'hFFFF_FFFE);
      check("mult_traces", traces, 32'd1);

      // Flush with stall: bubble loaded, HI/LO untouched.
      set_mem(2'b00, 1'b0, 2'b00, 5'd8, 3'b111, 32'h1234_5678, 32'd0, 32'd0,
              32'hBFC0_0500, 32'h0000_0077, 32'h0000_0088);
      WB_Flush = 1'b1; WB_Wr = 1'b0;
      tick();
      WB_Flush = 1'b0;
      check("flush_rfwr", {31'd0, WB_RFWr}, 32'd0);
      check("flush_dst",  {27'd0, WB_Dst}, 32'd0);
      check("flush_pc",   WB_PC, 32'hBFC0_0000);
      check("flush_wen",  {28'd0, debug_wb_rf_wen}, 32'd0);
      WB_Wr = 1'b1;
      #1;
      tick();
      check("flush_hi", WB_HI, 32'h0000_0001);
      check("flush_lo", WB_LO, 32'hFFFF_FFFE);

      // Reset while a HI/LO write sits in WB drops it.
      set_mem(2'b00, 1'b0, 2'b00, 5'd4, 3'b111, 32'd0, 32'd0, 32'd0,
              32'hBFC0_0600, 32'h0000_0005, 32'h0000_0006);
      tick();
      rst = 1'b1;
      #1;
      check("mid_rst_hi",   WB_HI, 32'd0);
      check("mid_rst_lo",   WB_LO, 32'd0);
      check("mid_rst_pc",   WB_PC, 32'hBFC0_0000);
      check("mid_rst_rfwr", {31'd0, WB_RFWr}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      set_mem(2'b00, 1'b0, 2'b00, 5'd0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      tick();
      check("post_rst_hi", WB_HI, 32'd0);
      check("post_rst_lo", WB_LO, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
